// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared encodings for the MIPS-subset decode stage
// Purpose: opcode/funct constants, ALU op codes, register-index width,
//          NOP encoding and the decoded control bundle.
// Ports:   none (package).
package mips_pkg;

  localparam int REG_AW = 5;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4
  } alu_op_e;

  typedef struct packed {
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    mem_to_reg;
    logic    alu_src;
    alu_op_e alu_op;
    logic    illegal;
  } ctrl_t;

endpackage

// File: rtl/decode_stage_if.sv
// rtl/decode_stage_if.sv - fetch/MEM/WB side bundle of the decode stage
// Purpose: groups every non-clock signal of decode_stage.
// Ports:   slave  = decode stage view (fetch, MEM and WB inputs; stall,
//                   redirect and ID/EX outputs)
//          master = environment view (the mirror image).
interface decode_stage_if
  import mips_pkg::*;
#(
  parameter int W = 32
);
  logic [W-1:0]      if_instr;
  logic [W-1:0]      if_pc4;
  logic              if_valid;
  logic              mem_reg_write;
  logic [REG_AW-1:0] mem_dst;
  logic              wb_we;
  logic [REG_AW-1:0] wb_addr;
  logic [W-1:0]      wb_data;

  logic              stall_if;
  logic              br_taken;
  logic [W-1:0]      br_target;
  logic              id_valid;
  logic [W-1:0]      id_rs_val;
  logic [W-1:0]      id_rt_val;
  logic [W-1:0]      id_imm;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic [REG_AW-1:0] id_dst;
  logic              id_reg_write;
  logic              id_mem_read;
  logic              id_mem_write;
  logic              id_mem_to_reg;
  logic              id_alu_src;
  logic [2:0]        id_alu_op;
  logic              id_illegal;

  modport slave (
    input  if_instr, if_pc4, if_valid, mem_reg_write, mem_dst,
           wb_we, wb_addr, wb_data,
    output stall_if, br_taken, br_target, id_valid, id_rs_val, id_rt_val,
           id_imm, id_rs, id_rt, id_dst, id_reg_write, id_mem_read,
           id_mem_write, id_mem_to_reg, id_alu_src, id_alu_op, id_illegal
  );

  modport master (
    output if_instr, if_pc4, if_valid, mem_reg_write, mem_dst,
           wb_we, wb_addr, wb_data,
    input  stall_if, br_taken, br_target, id_valid, id_rs_val, id_rt_val,
           id_imm, id_rs, id_rt, id_dst, id_reg_write, id_mem_read,
           id_mem_write, id_mem_to_reg, id_alu_src, id_alu_op, id_illegal
  );
endinterface

// File: rtl/reg_file.sv
// rtl/reg_file.sv - 2-read/1-write register file with write-through
// Purpose: architectural registers; r0 reads as zero and ignores writes.
// Ports:   clk, rst_n (async active-low), we_i/waddr_i/wdata_i write port,
//          raddr_a_i/rdata_a_o and raddr_b_i/rdata_b_o combinational reads.
module reg_file
  import mips_pkg::*;
#(
  parameter int NREG = 32,
  parameter int W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [REG_AW-1:0] waddr_i,
  input  logic [W-1:0]      wdata_i,
  input  logic [REG_AW-1:0] raddr_a_i,
  input  logic [REG_AW-1:0] raddr_b_i,
  output logic [W-1:0]      rdata_a_o,
  output logic [W-1:0]      rdata_b_o
);

  logic [W-1:0] regs_q [NREG];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i && (waddr_i != '0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  // Write-through lets decode see a value being written back this cycle.
  always_comb begin
    rdata_a_o = regs_q[raddr_a_i];
    rdata_b_o = regs_q[raddr_b_i];
    if (we_i && (waddr_i == raddr_a_i)) rdata_a_o = wdata_i;
    if (we_i && (waddr_i == raddr_b_i)) rdata_b_o = wdata_i;
    if (raddr_a_i == '0) rdata_a_o = '0;
    if (raddr_b_i == '0) rdata_b_o = '0;
  end

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - MIPS-subset instruction decode stage
// Purpose: IF/ID latch, register file, control decode, hazard detection,
//          branch/jump resolution and the ID/EX latch.
// Ports:   clk, inicio (async active-low reset), pipe (decode_stage_if.slave).
module decode_stage
  import mips_pkg::*;
#(
  parameter int NREG = 32,
  parameter int W    = 32
) (
  input  logic          clk,
  input  logic          inicio,
  decode_stage_if.slave pipe
);

  // IF/ID latch
  logic [W-1:0] ifid_instr_q, ifid_instr_d;
  logic [W-1:0] ifid_pc4_q, ifid_pc4_d;
  logic         ifid_valid_q, ifid_valid_d;

  // ID/EX latch
  logic              id_valid_q, id_valid_d;
  logic [W-1:0]      id_rs_val_q, id_rs_val_d;
  logic [W-1:0]      id_rt_val_q, id_rt_val_d;
  logic [W-1:0]      id_imm_q, id_imm_d;
  logic [REG_AW-1:0] id_rs_q, id_rs_d;
  logic [REG_AW-1:0] id_rt_q, id_rt_d;
  logic [REG_AW-1:0] id_dst_q, id_dst_d;
  ctrl_t             id_ctrl_q, id_ctrl_d;

  logic [5:0]        opcode, funct;
  logic [REG_AW-1:0] rs, rt, rd;
  logic [W-1:0]      imm_sext, rs_val, rt_val;

  assign opcode   = ifid_instr_q[31:26];
  assign rs       = ifid_instr_q[25:21];
  assign rt       = ifid_instr_q[20:16];
  assign rd       = ifid_instr_q[15:11];
  assign funct    = ifid_instr_q[5:0];
  assign imm_sext = {{(W-16){ifid_instr_q[15]}}, ifid_instr_q[15:0]};

  reg_file #(.NREG(NREG), .W(W)) u_reg_file (
    .clk       (clk),
    .rst_n     (inicio),
    .we_i      (pipe.wb_we),
    .waddr_i   (pipe.wb_addr),
    .wdata_i   (pipe.wb_data),
    .raddr_a_i (rs),
    .raddr_b_i (rt),
    .rdata_a_o (rs_val),
    .rdata_b_o (rt_val)
  );

  // Control decode
  ctrl_t             dec_ctrl;
  logic [REG_AW-1:0] dec_dst;
  logic              is_beq, is_bne, is_j, uses_rt;

  always_comb begin
    dec_ctrl = '0;
    dec_dst  = '0;
    is_beq   = 1'b0;
    is_bne   = 1'b0;
    is_j     = 1'b0;
    uses_rt  = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        uses_rt = 1'b1;
        // The all-zero word is sll r0 and is treated as a plain NOP.
        if (ifid_instr_q != NOP_INSTR) begin
          case (funct)
            FN_ADD:  dec_ctrl.alu_op = ALU_ADD;
            FN_SUB:  dec_ctrl.alu_op = ALU_SUB;
            FN_AND:  dec_ctrl.alu_op = ALU_AND;
            FN_OR:   dec_ctrl.alu_op = ALU_OR;
            FN_SLT:  dec_ctrl.alu_op = ALU_SLT;
            default: dec_ctrl.illegal = 1'b1;
          endcase
          if (!dec_ctrl.illegal) begin
            dec_ctrl.reg_write = 1'b1;
            dec_dst            = rd;
          end
        end
      end
      OP_ADDI: begin
        dec_ctrl.reg_write = 1'b1;
        dec_ctrl.alu_src   = 1'b1;
        dec_dst            = rt;
      end
      OP_LW: begin
        dec_ctrl.reg_write  = 1'b1;
        dec_ctrl.mem_read   = 1'b1;
        dec_ctrl.mem_to_reg = 1'b1;
        dec_ctrl.alu_src    = 1'b1;
        dec_dst             = rt;
      end
      OP_SW: begin
        dec_ctrl.mem_write = 1'b1;
        dec_ctrl.alu_src   = 1'b1;
        uses_rt            = 1'b1;
      end
      OP_BEQ: begin
        is_beq  = 1'b1;
        uses_rt = 1'b1;
      end
      OP_BNE: begin
        is_bne  = 1'b1;
        uses_rt = 1'b1;
      end
      OP_J:    is_j = 1'b1;
      default: dec_ctrl.illegal = 1'b1;
    endcase
  end

  // Hazards. Branches compare in decode, so any producer still in EX or MEM
  // must drain before the comparison is trusted.
  logic load_use, br_stall, rs_busy, rt_busy, stall;

  assign load_use = ifid_valid_q && id_ctrl_q.mem_read && (id_dst_q != '0) &&
                    ((id_dst_q == rs) || (uses_rt && (id_dst_q == rt)));

  assign rs_busy = (rs != '0) &&
                   ((id_ctrl_q.reg_write && (id_dst_q == rs)) ||
                    (pipe.mem_reg_write && (pipe.mem_dst == rs)));
  assign rt_busy = (rt != '0) &&
                   ((id_ctrl_q.reg_write && (id_dst_q == rt)) ||
                    (pipe.mem_reg_write && (pipe.mem_dst == rt)));

  assign br_stall = ifid_valid_q && (is_beq || is_bne) && (rs_busy || rt_busy);
  assign stall    = load_use || br_stall;

  // Redirect
  logic         taken;
  logic [W-1:0] branch_tgt, jump_tgt;

  assign branch_tgt = ifid_pc4_q + {imm_sext[W-3:0], 2'b00};
  assign jump_tgt   = {ifid_pc4_q[W-1:28], ifid_instr_q[25:0], 2'b00};
  assign taken      = ifid_valid_q && !stall &&
                      ((is_beq && (rs_val == rt_val)) ||
                       (is_bne && (rs_val != rt_val)) || is_j);

  // Next-state for both latches
  always_comb begin
    ifid_instr_d = pipe.if_instr;
    ifid_pc4_d   = pipe.if_pc4;
    ifid_valid_d = pipe.if_valid;
    if (stall) begin
      ifid_instr_d = ifid_instr_q;
      ifid_pc4_d   = ifid_pc4_q;
      ifid_valid_d = ifid_valid_q;
    end else if (taken) begin
      ifid_instr_d = '0;
      ifid_pc4_d   = '0;
      ifid_valid_d = 1'b0;
    end

    id_valid_d  = 1'b0;
    id_rs_val_d = '0;
    id_rt_val_d = '0;
    id_imm_d    = '0;
    id_rs_d     = '0;
    id_rt_d     = '0;
    id_dst_d    = '0;
    id_ctrl_d   = '0;
    if (ifid_valid_q && !stall) begin
      id_valid_d  = 1'b1;
      id_rs_val_d = rs_val;
      id_rt_val_d = rt_val;
      id_imm_d    = imm_sext;
      id_rs_d     = rs;
      id_rt_d     = rt;
      id_dst_d    = dec_dst;
      id_ctrl_d   = dec_ctrl;
    end
  end

  always_ff @(posedge clk or negedge inicio) begin
    if (!inicio) begin
      ifid_instr_q <= '0;
      ifid_pc4_q   <= '0;
      ifid_valid_q <= 1'b0;
      id_valid_q   <= 1'b0;
      id_rs_val_q  <= '0;
      id_rt_val_q  <= '0;
      id_imm_q     <= '0;
      id_rs_q      <= '0;
      id_rt_q      <= '0;
      id_dst_q     <= '0;
      id_ctrl_q    <= '0;
    end else begin
      ifid_instr_q <= ifid_instr_d;
      ifid_pc4_q   <= ifid_pc4_d;
      ifid_valid_q <= ifid_valid_d;
      id_valid_q   <= id_valid_d;
      id_rs_val_q  <= id_rs_val_d;
      id_rt_val_q  <= id_rt_val_d;
      id_imm_q     <= id_imm_d;
      id_rs_q      <= id_rs_d;
      id_rt_q      <= id_rt_d;
      id_dst_q     <= id_dst_d;
      id_ctrl_q    <= id_ctrl_d;
    end
  end

  assign pipe.stall_if      = stall;
  assign pipe.br_taken      = taken;
  assign pipe.br_target     = is_j ? jump_tgt : branch_tgt;
  assign pipe.id_valid      = id_valid_q;
  assign pipe.id_rs_val     = id_rs_val_q;
  assign pipe.id_rt_val     = id_rt_val_q;
  assign pipe.id_imm        = id_imm_q;
  assign pipe.id_rs         = id_rs_q;
  assign pipe.id_rt         = id_rt_q;
  assign pipe.id_dst        = id_dst_q;
  assign pipe.id_reg_write  = id_ctrl_q.reg_write;
  assign pipe.id_mem_read   = id_ctrl_q.mem_read;
  assign pipe.id_mem_write  = id_ctrl_q.mem_write;
  assign pipe.id_mem_to_reg = id_ctrl_q.mem_to_reg;
  assign pipe.id_alu_src    = id_ctrl_q.alu_src;
  assign pipe.id_alu_op     = id_ctrl_q.alu_op;
  assign pipe.id_illegal    = id_ctrl_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - self-checking bench for decode_stage
module tb_decode_stage;

  logic clk = 1'b0;
  logic inicio = 1'b0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  decode_stage_if #(.W(32)) pipe ();

  decode_stage #(.NREG(32), .W(32)) dut (
    .clk    (clk),
    .inicio (inicio),
    .pipe   (pipe.slave)
  );

  // ctrl = {reg_write, mem_read, mem_write, mem_to_reg, alu_src}
  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        br;
    logic [31:0] tgt;
    logic [4:0]  ctrl;
    logic [2:0]  alu;
    logic        ill;
    logic [4:0]  dst;
    logic [31:0] rsv;
    logic [31:0] rtv;
  } vec_t;

  vec_t vecs [16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
    pipe.wb_we = 1'b1; pipe.wb_addr = a; pipe.wb_data = d;
    tick();
    pipe.wb_we = 1'b0; pipe.wb_addr = '0; pipe.wb_data = '0;
  endtask

  function automatic logic [4:0] ctrl_bits();
    return {pipe.id_reg_write, pipe.id_mem_read, pipe.id_mem_write,
            pipe.id_mem_to_reg, pipe.id_alu_src};
  endfunction

  initial begin
    vecs[0]  = '{32'h00221820, 32'h0, 1'b0, 32'h0, 5'b10000, 3'd0, 1'b0, 5'd3, 32'd5, 32'd7};
    vecs[1]  = '{32'h00222022, 32'h0, 1'b0, 32'h0, 5'b10000, 3'd1, 1'b0, 5'd4, 32'd5, 32'd7};
    vecs[2]  = '{32'h00222824, 32'h0, 1'b0, 32'h0, 5'b10000, 3'd2, 1'b0, 5'd5, 32'd5, 32'd7};
    vecs[3]  = '{32'h00223025, 32'h0, 1'b0, 32'h0, 5'b10000, 3'd3, 1'b0, 5'd6, 32'd5, 32'd7};
    vecs[4]  = '{32'h0022382A, 32'h0, 1'b0, 32'h0, 5'b10000, 3'd4, 1'b0, 5'd7, 32'd5, 32'd7};
    vecs[5]  = '{32'h2028FFFF, 32'h0, 1'b0, 32'h0, 5'b10001, 3'd0, 1'b0, 5'd8, 32'd5, 32'd0};
    vecs[6]  = '{32'h8C490008, 32'h0, 1'b0, 32'h0, 5'b11011, 3'd0, 1'b0, 5'd9, 32'd7, 32'd0};
    vecs[7]  = '{32'hAC410004, 32'h0, 1'b0, 32'h0, 5'b00101, 3'd0, 1'b0, 5'd0, 32'd7, 32'd5};
    vecs[8]  = '{32'h00000000, 32'h0, 1'b0, 32'h0, 5'b00000, 3'd0, 1'b0, 5'd0, 32'd0, 32'd0};
    vecs[9]  = '{32'hFC000000, 32'h0, 1'b0, 32'h0, 5'b00000, 3'd0, 1'b1, 5'd0, 32'd0, 32'd0};
    vecs[10] = '{32'h00221821, 32'h0, 1'b0, 32'h0, 5'b00000, 3'd0, 1'b1, 5'd0, 32'd5, 32'd7};
    vecs[11] = '{32'h08000040, 32'h10000104, 1'b1, 32'h10000100, 5'b00000, 3'd0, 1'b0, 5'd0, 32'd0, 32'd0};
    vecs[12] = '{32'h14220002, 32'h00000200, 1'b1, 32'h00000208, 5'b00000, 3'd0, 1'b0, 5'd0, 32'd5, 32'd7};
    vecs[13] = '{32'h1022FFFF, 32'h00000300, 1'b0, 32'h0, 5'b00000, 3'd0, 1'b0, 5'd0, 32'd5, 32'd7};
    vecs[14] = '{32'h14210001, 32'h00000400, 1'b0, 32'h0, 5'b00000, 3'd0, 1'b0, 5'd0, 32'd5, 32'd5};
    vecs[15] = '{32'h1000FFFC, 32'h00000008, 1'b1, 32'hFFFFFFF8, 5'b00000, 3'd0, 1'b0, 5'd0, 32'd0, 32'd0};

    pipe.if_instr = '0; pipe.if_pc4 = '0; pipe.if_valid = 1'b0;
    pipe.mem_reg_write = 1'b0; pipe.mem_dst = '0;
    pipe.wb_we = 1'b0; pipe.wb_addr = '0; pipe.wb_data = '0;

    // Reset state
    tick(); tick();
    chk("rst_valid", {31'b0, pipe.id_valid}, 32'd0);
    chk("rst_ctrl", {27'b0, ctrl_bits()}, 32'd0);
    chk("rst_stall", {31'b0, pipe.stall_if}, 32'd0);
    chk("rst_br", {31'b0, pipe.br_taken}, 32'd0);
    chk("rst_dst", {27'b0, pipe.id_dst}, 32'd0);
    inicio = 1'b1;
    tick();

    wb_write(5'd1, 32'd5);
    wb_write(5'd2, 32'd7);

    // Table-driven single-instruction decode
    for (int i = 0; i < 16; i++) begin
      pipe.if_instr = vecs[i].instr; pipe.if_pc4 = vecs[i].pc4; pipe.if_valid = 1'b1;
      tick();
      chk($sformatf("v%0d_stall", i), {31'b0, pipe.stall_if}, 32'd0);
      chk($sformatf("v%0d_br", i), {31'b0, pipe.br_taken}, {31'b0, vecs[i].br});
      if (vecs[i].br) chk($sformatf("v%0d_tgt", i), pipe.br_target, vecs[i].tgt);
      pipe.if_instr = '0; pipe.if_pc4 = '0; pipe.if_valid = 1'b0;
      tick();
      chk($sformatf("v%0d_valid", i), {31'b0, pipe.id_valid}, 32'd1);
      chk($sformatf("v%0d_ctrl", i), {27'b0, ctrl_bits()}, {27'b0, vecs[i].ctrl});
      chk($sformatf("v%0d_alu", i), {29'b0, pipe.id_alu_op}, {29'b0, vecs[i].alu});
      chk($sformatf("v%0d_ill", i), {31'b0, pipe.id_illegal}, {31'b0, vecs[i].ill});
      chk($sformatf("v%0d_dst", i), {27'b0, pipe.id_dst}, {27'b0, vecs[i].dst});
      chk($sformatf("v%0d_imm", i), pipe.id_imm, {{16{vecs[i].instr[15]}}, vecs[i].instr[15:0]});
      chk($sformatf("v%0d_rs", i), {27'b0, pipe.id_rs}, {27'b0, vecs[i].instr[25:21]});
      chk($sformatf("v%0d_rt", i), {27'b0, pipe.id_rt}, {27'b0, vecs[i].instr[20:16]});
      chk($sformatf("v%0d_rsval", i), pipe.id_rs_val, vecs[i].rsv);
      chk($sformatf("v%0d_rtval", i), pipe.id_rt_val, vecs[i].rtv);
      tick();
    end

    // Write-through: or r5,r4,r0 read while r4 is being written
    pipe.if_instr = 32'h00802825; pipe.if_valid = 1'b1;
    tick();
    pipe.if_valid = 1'b0; pipe.if_instr = '0;
    pipe.wb_we = 1'b1; pipe.wb_addr = 5'd4; pipe.wb_data = 32'h0000DEAD;
    tick();
    pipe.wb_we = 1'b0; pipe.wb_addr = '0; pipe.wb_data = '0;
    chk("wt_rs_val", pipe.id_rs_val, 32'h0000DEAD);
    chk("wt_rt_val", pipe.id_rt_val, 32'h0);
    tick();

    // r0 stays zero, both stored and write-through
    pipe.wb_we = 1'b1; pipe.wb_addr = 5'd0; pipe.wb_data = 32'h0000FFFF;
    tick();
    pipe.if_instr = 32'h00002825; pipe.if_valid = 1'b1;
    tick();
    pipe.if_valid = 1'b0; pipe.if_instr = '0;
    tick();
    pipe.wb_we = 1'b0; pipe.wb_data = '0;
    chk("r0_rs_val", pipe.id_rs_val, 32'h0);
    chk("r0_rt_val", pipe.id_rt_val, 32'h0);
    tick();

    // Load-use: lw r2,0(r1) ; add r3,r2,r2
    pipe.if_instr = 32'h8C220000; pipe.if_valid = 1'b1;
    tick();
    pipe.if_instr = 32'h00421820;
    tick();
    chk("lu_stall", {31'b0, pipe.stall_if}, 32'd1);
    chk("lu_memrd", {31'b0, pipe.id_mem_read}, 32'd1);
    chk("lu_lw_dst", {27'b0, pipe.id_dst}, 32'd2);
    tick();
    chk("lu_stall_once", {31'b0, pipe.stall_if}, 32'd0);
    chk("lu_bubble", {31'b0, pipe.id_valid}, 32'd0);
    chk("lu_bubble_ctrl", {27'b0, ctrl_bits()}, 32'd0);
    pipe.if_valid = 1'b0; pipe.if_instr = '0;
    tick();
    chk("lu_add_valid", {31'b0, pipe.id_valid}, 32'd1);
    chk("lu_add_rs", {27'b0, pipe.id_rs}, 32'd2);
    chk("lu_add_dst", {27'b0, pipe.id_dst}, 32'd3);
    tick(); tick();

    // Branch taken: r1=r2=9, beq r1,r2,+3 at pc4=0x100
    wb_write(5'd1, 32'd9);
    wb_write(5'd2, 32'd9);
    pipe.if_instr = 32'h10220003; pipe.if_pc4 = 32'h100; pipe.if_valid = 1'b1;
    tick();
    chk("bt_taken", {31'b0, pipe.br_taken}, 32'd1);
    chk("bt_target", pipe.br_target, 32'h0000010C);
    pipe.if_instr = 32'h00221820; pipe.if_pc4 = 32'h104;
    tick();
    chk("bt_id_valid", {31'b0, pipe.id_valid}, 32'd1);
    chk("bt_id_ctrl", {27'b0, ctrl_bits()}, 32'd0);
    chk("bt_slot_br", {31'b0, pipe.br_taken}, 32'd0);
    pipe.if_valid = 1'b0; pipe.if_instr = '0; pipe.if_pc4 = '0;
    tick();
    chk("bt_squashed", {31'b0, pipe.id_valid}, 32'd0);
    tick();

    // Branch hazard: addi r1,r1,1 ; beq r1,r2,+3
    pipe.if_instr = 32'h20210001; pipe.if_valid = 1'b1;
    tick();
    pipe.if_instr = 32'h10220003; pipe.if_pc4 = 32'h100;
    tick();
    chk("bh_stall_ex", {31'b0, pipe.stall_if}, 32'd1);
    chk("bh_br_held", {31'b0, pipe.br_taken}, 32'd0);
    pipe.mem_reg_write = 1'b1; pipe.mem_dst = 5'd1;
    pipe.if_valid = 1'b0; pipe.if_instr = '0; pipe.if_pc4 = '0;
    tick();
    chk("bh_stall_mem", {31'b0, pipe.stall_if}, 32'd1);
    chk("bh_bubble", {31'b0, pipe.id_valid}, 32'd0);
    pipe.mem_reg_write = 1'b0; pipe.mem_dst = '0;
    pipe.wb_we = 1'b1; pipe.wb_addr = 5'd1; pipe.wb_data = 32'd10;
    #1;
    chk("bh_resolved", {31'b0, pipe.stall_if}, 32'd0);
    chk("bh_untaken", {31'b0, pipe.br_taken}, 32'd0);
    tick();
    pipe.wb_we = 1'b0; pipe.wb_addr = '0; pipe.wb_data = '0;
    chk("bh_beq_valid", {31'b0, pipe.id_valid}, 32'd1);
    chk("bh_rs_val", pipe.id_rs_val, 32'd10);
    chk("bh_rt_val", pipe.id_rt_val, 32'd9);
    tick(); tick();

    // Reset pulsed during a load-use stall
    pipe.if_instr = 32'h8C220000; pipe.if_valid = 1'b1;
    tick();
    pipe.if_instr = 32'h00421820;
    tick();
    chk("rs_pre_stall", {31'b0, pipe.stall_if}, 32'd1);
    inicio = 1'b0;
    #1;
    chk("rs_stall", {31'b0, pipe.stall_if}, 32'd0);
    chk("rs_valid", {31'b0, pipe.id_valid}, 32'd0);
    chk("rs_ctrl", {27'b0, ctrl_bits()}, 32'd0);
    chk("rs_dst", {27'b0, pipe.id_dst}, 32'd0);
    chk("rs_br", {31'b0, pipe.br_taken}, 32'd0);
    pipe.if_valid = 1'b0; pipe.if_instr = '0;
    tick();
    inicio = 1'b1;
    tick();
    chk("rs_after_stall", {31'b0, pipe.stall_if}, 32'd0);

    // Registers cleared by reset: add r3,r1,r2 reads zeros
    pipe.if_instr = 32'h00221820; pipe.if_valid = 1'b1;
    tick();
    pipe.if_valid = 1'b0; pipe.if_instr = '0;
    tick();
    chk("rs_r1_cleared", pipe.id_rs_val, 32'd0);
    chk("rs_r2_cleared", pipe.id_rt_val, 32'd0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Instruction-decode stage of the 5-stage MIPS-subset pipeline, directly downstream of the fetch stage that drives Pipe.
- Holds the IF/ID latch, the 32x32 register file with WB write-through, the control decoder and the ID/EX output latch.
- Resolves beq/bne/j in decode and returns stall and redirect signals to fetch.

Parameters:
- NREG, 32, number of architectural registers; r0 is hardwired to 0.
- W, 32, data and address width.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- inicio  in  1  reset, asynchronous, active-low.
- if_instr  in  W  instruction from fetch.
- if_pc4  in  W  PC+4 of if_instr.
- if_valid  in  1  if_instr is real (not a bubble).
- mem_reg_write, mem_dst  in  1,5  writer currently in the MEM stage (used for the branch hazard check).
- wb_we, wb_addr, wb_data  in  1,5,W  register-file write port.
- stall_if  out  1  fetch holds PC; IF/ID holds its contents.
- br_taken, br_target  out  1,W  redirect to fetch; combinational.
- id_valid, id_rs_val, id_rt_val, id_imm  out  1,W,W,W  ID/EX latch: operand values and sign-extended immediate.
- id_rs, id_rt, id_dst  out  5 each  register numbers; id_dst is already muxed between rd and rt.
- id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src  out  1 each  control bits.
- id_alu_op  out  3  ALU operation.
- id_illegal  out  1  opcode or funct not supported.

Behaviour:
- Reset (inicio=0, async): IF/ID cleared (instr=0, valid=0). Every ID/EX output is 0. All registers are 0.
- Latency: an instruction captured into IF/ID at edge N appears on the id_* outputs after edge N+1.
- Decoded set:
  - R-type funct: add 100000, sub 100010, and 100100, or 100101, slt 101010.
  - I/J opcodes: addi 001000, lw 100011, sw 101011, beq 000100, bne 000101, j 000010.
  - Word 0 (sll r0) is a NOP: valid, no control bits set.
  - Any other opcode/funct: all control bits 0, id_illegal=1.
- Register file:
  - Write on the edge when wb_we=1 and wb_addr!=0; writes to r0 are ignored.
  - Reads are combinational with write-through: if wb_we=1 and wb_addr==src and src!=0, the read returns wb_data.
- Load-use stall: asserted when IF/ID is valid, id_mem_read=1, id_dst!=0, and id_dst equals rs, or equals rt for R-type/beq/bne/sw.
- Branch stall: asserted when the IF/ID instruction is beq/bne and rs or rt (nonzero) matches either:
  - id_dst with id_reg_write=1, or
  - mem_dst with mem_reg_write=1.
- stall_if = load-use stall OR branch stall.
- While stalled: IF/ID holds; ID/EX loads a bubble (all control 0, id_valid=0).
- br_taken is valid only when IF/ID is valid and stall_if=0:
  - beq and rs_val==rt_val, or bne and rs_val!=rt_val: br_target = pc4 + (sext(imm) << 2).
  - j: br_target = {pc4[31:28], instr[25:0], 2'b00}.
  - Otherwise br_taken=0 and br_target is don't-care.
- IF/ID update priority: stall (hold) > br_taken (load bubble, squashing the fetched slot) > load if_instr/if_valid.
- Branches and jumps pass to ID/EX with all control bits 0.
- id_dst: rd for R-type, rt for addi/lw.
- id_alu_src=1 for addi/lw/sw. id_imm is always sext(instr[15:0]).
- Target arithmetic wraps modulo 2^32.
- Reset asserted mid-operation clears in-flight state immediately; no pending stall or redirect survives reset.

Decomposition:
- Package mips_pkg holds:
  - opcode and funct constants;
  - ALU op codes: ADD=0, SUB=1, AND=2, OR=3, SLT=4;
  - register-index width (5) and NOP encoding.
- One sub-module: reg_file, 32x32 with 2 read ports, 1 write port, write-through and r0 forced to 0.
- Control decode, hazard logic and the latches stay in decode_stage.

Test Plan:
- Reset, then write r1=5 and r2=7 via WB; decode add r3,r1,r2 (0x00221820) -> one cycle later: id_rs_val=5, id_rt_val=7, id_dst=3, id_reg_write=1, id_alu_op=ADD, id_valid=1.
- Write-through: wb_we=1, wb_addr=4, wb_data=0xDEAD in the same cycle IF/ID holds or r5,r4,r0 -> id_rs_val=0xDEAD. Writing r0=0xFFFF and then reading r0 -> 0.
- Load-use: lw r2,0(r1) followed by add r3,r2,r2 -> stall_if=1 for exactly one cycle, one bubble (id_valid=0) on the outputs, then add issues with id_rs=2.
- Branch taken: r1=r2=9, beq r1,r2,+3 at pc4=0x100 -> br_taken=1, br_target=0x10C; the next IF/ID content is a bubble.
- Branch untaken and hazard: bne r1,r1 -> br_taken=0. beq directly after addi r1,... -> stall_if=1 while the addi occupies ID/EX, then again while it is in MEM (mem_reg_write=1, mem_dst=1), then resolves.
- Illegal 0xFC000000 -> id_illegal=1 with all control 0. inicio pulsed low during a stall -> all outputs 0 immediately and stall_if=0.
